// File: rtl/sp_pkg.sv
// Shared types and constants for the sp_rx8 serial receiver.
package sp_pkg;

  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned BIT_CNT_W   = 3;
  localparam int unsigned COMMA_CNT_W = 3;

  localparam logic [BYTE_W-1:0] SP_COMMA = 8'hBC;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'b00,
    ST_ALIGN  = 2'b01,
    ST_ACTIVE = 2'b10
  } sp_state_e;

  // Comma counter increment that sticks at the alignment target.
  function automatic logic [COMMA_CNT_W-1:0] comma_sat_inc(
    input logic [COMMA_CNT_W-1:0] cnt,
    input logic [COMMA_CNT_W-1:0] limit
  );
    return (cnt >= limit) ? limit : COMMA_CNT_W'(cnt + 1'b1);
  endfunction

endpackage

// File: rtl/sp_shift8.sv
// 8-bit serial-in/parallel-out shift register made of per-bit enabled flops.
module sp_shift8
  import sp_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET_L,
  input  logic              EN,
  input  logic              D,
  output logic [BYTE_W-1:0] Q
);

  logic [BYTE_W-1:0] shift_in;

  assign shift_in = {Q[BYTE_W-2:0], D};

  for (genvar i = 0; i < BYTE_W; i++) begin : g_bit
    always_ff @(posedge CLK or negedge RESET_L) begin
      if (!RESET_L) begin
        Q[i] <= 1'b0;
      end else if (EN) begin
        Q[i] <= shift_in[i];
      end
    end
  end

endmodule

// File: rtl/sp_rx8.sv
// Serial-to-parallel receiver: comma search, alignment, byte emission.
// Build option: define SP_IDLE_FILTER_EN to drop comma bytes once aligned.
module sp_rx8
  import sp_pkg::*;
#(
  parameter logic [BYTE_W-1:0] COMMA       = SP_COMMA,
  parameter int unsigned       ALIGN_COUNT = 4
) (
  input  logic              CLK,
  input  logic              RESET_L,
  input  logic              EN,
  input  logic              D,
  output logic [BYTE_W-1:0] Q,
  output logic              VALID,
  output logic              ACTIVE
);

  localparam logic [COMMA_CNT_W-1:0] ALIGN_CNT = COMMA_CNT_W'(ALIGN_COUNT);
  localparam logic [BIT_CNT_W-1:0]   LAST_BIT  = BIT_CNT_W'(BYTE_W - 1);

  sp_state_e               state_q, state_d;
  logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [COMMA_CNT_W-1:0]  comma_cnt_q, comma_cnt_d;
  logic [COMMA_CNT_W-1:0]  comma_next;
  logic [BYTE_W-1:0]       q_d;
  logic                    valid_d;
  logic                    active_d;

  logic [BYTE_W-1:0]       shift;
  logic [BYTE_W-1:0]       window;
  logic                    unused_shift_msb;
  logic                    byte_edge;
  logic                    is_comma;

  sp_shift8 u_shift (
    .CLK     (CLK),
    .RESET_L (RESET_L),
    .EN      (EN),
    .D       (D),
    .Q       (shift)
  );

  // The oldest bit falls out of the window as the new one arrives.
  assign unused_shift_msb = shift[BYTE_W-1];
  assign window           = {shift[BYTE_W-2:0], D};
  assign byte_edge        = (bit_cnt_q == LAST_BIT);
  assign is_comma         = (window == COMMA);
  assign comma_next       = comma_sat_inc(comma_cnt_q, ALIGN_CNT);

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q     <= ST_SEARCH;
      bit_cnt_q   <= '0;
      comma_cnt_q <= '0;
      Q           <= '0;
      VALID       <= 1'b0;
      ACTIVE      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      Q           <= q_d;
      VALID       <= valid_d;
      ACTIVE      <= active_d;
    end
  end

  // Next-state and output decode; nothing moves on EN=0 edges except VALID.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    comma_cnt_d = comma_cnt_q;
    q_d         = Q;
    valid_d     = 1'b0;
    active_d    = ACTIVE;

    if (EN) begin
      case (state_q)
        ST_SEARCH: begin
          if (is_comma) begin
            bit_cnt_d   = '0;
            comma_cnt_d = COMMA_CNT_W'(1);
            state_d     = ST_ALIGN;
          end
        end

        ST_ALIGN: begin
          bit_cnt_d = BIT_CNT_W'(bit_cnt_q + 1'b1);
          if (byte_edge) begin
            if (is_comma) begin
              if (comma_next == ALIGN_CNT) begin
                state_d     = ST_ACTIVE;
                active_d    = 1'b1;
                comma_cnt_d = '0;
              end else begin
                comma_cnt_d = comma_next;
              end
            end else begin
              // Broken run: restart the search from the following bit.
              state_d     = ST_SEARCH;
              comma_cnt_d = '0;
            end
          end
        end

        ST_ACTIVE: begin
          bit_cnt_d = BIT_CNT_W'(bit_cnt_q + 1'b1);
          if (byte_edge) begin
`ifdef SP_IDLE_FILTER_EN
            if (!is_comma) begin
              q_d     = window;
              valid_d = 1'b1;
            end
`else
            q_d     = window;
            valid_d = 1'b1;
`endif
          end
        end

        default: begin
          state_d = ST_SEARCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sp_rx8.sv
// Directed bench for sp_rx8 with an expected-byte scoreboard.
module tb_sp_rx8;

  logic       CLK;
  logic       RESET_L;
  logic       EN;
  logic       D;
  logic [7:0] Q;
  logic       VALID;
  logic       ACTIVE;

  int         checks;
  int         errors;
  int         valid_count;
  logic       exp_active;
  logic [7:0] sb[$];

  sp_rx8 dut (
    .CLK     (CLK),
    .RESET_L (RESET_L),
    .EN      (EN),
    .D       (D),
    .Q       (Q),
    .VALID   (VALID),
    .ACTIVE  (ACTIVE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Compare outputs just after an edge; pop the scoreboard when a byte is due.
  task automatic sample(input logic exp_valid);
    logic [7:0] e;
    if (VALID === 1'b1) valid_count++;
    chk1("valid", VALID, exp_valid);
    chk1("active", ACTIVE, exp_active);
    if (exp_valid) begin
      if (sb.size() == 0) begin
        chk1("scoreboard_empty", 1'b1, 1'b0);
      end else begin
        e = sb.pop_front();
        chk8("q", Q, e);
      end
    end
  endtask

  task automatic clk_bit(input logic en, input logic b, input logic exp_valid);
    @(negedge CLK);
    EN = en;
    D  = b;
    @(posedge CLK);
    #1;
    sample(exp_valid);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic emit, input logic act_at_lsb);
    logic [7:0] v;
    v = b;
    if (emit) sb.push_back(v);
    for (int i = 7; i >= 0; i--) begin
      if (i == 0 && act_at_lsb) exp_active = 1'b1;
      clk_bit(1'b1, v[i], emit && (i == 0));
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET_L    = 1'b0;
    EN         = 1'b0;
    D          = 1'b0;
    exp_active = 1'b0;
    repeat (2) @(negedge CLK);
    RESET_L = 1'b1;
  endtask

  initial begin
    logic [7:0] c3;
    int         vc0;
    checks      = 0;
    errors      = 0;
    valid_count = 0;
    exp_active  = 1'b0;
    RESET_L     = 1'b0;
    EN          = 1'b0;
    D           = 1'b0;
    #12;
    chk8("reset_q", Q, 8'h00);
    chk1("reset_valid", VALID, 1'b0);
    chk1("reset_active", ACTIVE, 1'b0);
    @(negedge CLK);
    RESET_L = 1'b1;

    // Idle zeros never align or emit.
    for (int i = 0; i < 40; i++) clk_bit(1'b1, 1'b0, 1'b0);
    chk8("zeros_q", Q, 8'h00);

    // Garbage bits, four commas, then two data bytes.
    clk_bit(1'b1, 1'b0, 1'b0);
    clk_bit(1'b1, 1'b1, 1'b0);
    clk_bit(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) send_byte(8'hBC, 1'b0, 1'b0);
    send_byte(8'hBC, 1'b0, 1'b1);
    send_byte(8'h5A, 1'b1, 1'b0);
    send_byte(8'h3C, 1'b1, 1'b0);

    // Broken comma run falls back to search.
    do_reset();
    send_byte(8'hBC, 1'b0, 1'b0);
    send_byte(8'hBC, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) send_byte(8'hBC, 1'b0, 1'b0);
    send_byte(8'hBC, 1'b0, 1'b1);
    send_byte(8'hA5, 1'b1, 1'b0);

    // Comma inside an active stream.
    vc0 = valid_count;
    send_byte(8'h11, 1'b1, 1'b0);
`ifdef SP_IDLE_FILTER_EN
    send_byte(8'hBC, 1'b0, 1'b0);
    chk8("idle_q_hold", Q, 8'h11);
`else
    send_byte(8'hBC, 1'b1, 1'b0);
`endif
    send_byte(8'h22, 1'b1, 1'b0);
`ifdef SP_IDLE_FILTER_EN
    chk8("valid_count", 8'(valid_count - vc0), 8'd2);
`else
    chk8("valid_count", 8'(valid_count - vc0), 8'd3);
`endif

    // EN stall in the middle of a byte.
    c3 = 8'hC3;
    sb.push_back(c3);
    for (int i = 7; i >= 4; i--) clk_bit(1'b1, c3[i], 1'b0);
    for (int k = 0; k < 5; k++) clk_bit(1'b0, k[0], 1'b0);
    for (int i = 3; i >= 0; i--) clk_bit(1'b1, c3[i], i == 0);
    chk8("stall_q", Q, 8'hC3);

    // Asynchronous reset mid-byte clears outputs before the next edge.
    for (int i = 7; i >= 5; i--) clk_bit(1'b1, 1'b1, 1'b0);
    #2;
    RESET_L    = 1'b0;
    exp_active = 1'b0;
    #1;
    chk8("async_q", Q, 8'h00);
    chk1("async_valid", VALID, 1'b0);
    chk1("async_active", ACTIVE, 1'b0);
    repeat (2) @(negedge CLK);
    RESET_L = 1'b1;

    // Data without realignment is ignored; commas bring the link back.
    send_byte(8'h5A, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) send_byte(8'hBC, 1'b0, 1'b0);
    send_byte(8'hBC, 1'b0, 1'b1);
    send_byte(8'h77, 1'b1, 1'b0);

    chk8("scoreboard_left", 8'(sb.size()), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
